// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use stall, branch flush and memory-wait freeze control for the 5-stage pipe
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int TIMEOUT      = 255,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      IF_ID_Instruction,
    input  logic [31:0]      ID_EX_Instruction,
    input  logic             ID_EX_MemRead,
    input  logic             EX_BranchTaken,
    input  logic             MEM_Busy,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             PipeFreeze,
    output logic [1:0]       State,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count,
    output logic             Timeout_Err
);

    localparam int FC_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [FC_W-1:0]   FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_FLUSH    = 2'b01,
        ST_MEM_WAIT = 2'b10,
        ST_BAD      = 2'b11
    } state_t;

    state_t            state_q;
    state_t            ret_q;
    state_t            act_state;
    logic [FC_W-1:0]   fcnt_q;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_nxt;

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rs1_used;
    logic       rs2_used;
    logic       load_use;
    logic       unused_bits;

    assign opcode = IF_ID_Instruction[6:0];
    assign rs1    = IF_ID_Instruction[19:15];
    assign rs2    = IF_ID_Instruction[24:20];
    assign rd     = ID_EX_Instruction[11:7];

    assign rs1_used = !((opcode == 7'b0110111) || (opcode == 7'b0010111) || (opcode == 7'b1101111));
    assign rs2_used = (opcode == 7'b0110011) || (opcode == 7'b0100011) || (opcode == 7'b1100011);
    assign load_use = ID_EX_MemRead && (rd != 5'd0) &&
                      ((rs1_used && (rd == rs1)) || (rs2_used && (rd == rs2)));

    assign unused_bits = ^{IF_ID_Instruction[31:25], IF_ID_Instruction[14:7],
                           ID_EX_Instruction[31:12], ID_EX_Instruction[6:0]};

    // The cycle MEM_Busy drops in MEM_WAIT behaves fully as the state being returned to.
    assign act_state = ((state_q == ST_MEM_WAIT) && !MEM_Busy) ? ret_q : state_q;

    assign wait_nxt = (act_state != ST_MEM_WAIT) ? WAIT_W'(1) :
                      (wait_q == WAIT_MAX)       ? wait_q     : wait_q + WAIT_W'(1);

    assign State = state_q;

    always_comb begin
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        PipeFreeze  = 1'b0;
        if (!reset) begin
            case (act_state)
                ST_RUN: begin
                    if (MEM_Busy) begin
                        PipeFreeze  = 1'b1;
                        PCWrite     = 1'b0;
                        IF_ID_Write = 1'b0;
                    end else if (EX_BranchTaken) begin
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = 1'b1;
                    end else if (load_use) begin
                        PCWrite     = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_EX_Flush = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (MEM_Busy) begin
                        PipeFreeze  = 1'b1;
                        PCWrite     = 1'b0;
                        IF_ID_Write = 1'b0;
                    end else begin
                        IF_ID_Flush = 1'b1;
                        ID_EX_Flush = EX_BranchTaken;
                    end
                end
                ST_MEM_WAIT: begin
                    PipeFreeze  = 1'b1;
                    PCWrite     = 1'b0;
                    IF_ID_Write = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            ret_q       <= ST_RUN;
            fcnt_q      <= '0;
            wait_q      <= '0;
            Stall_Count <= '0;
            Flush_Count <= '0;
            Timeout_Err <= 1'b0;
        end else begin
            wait_q <= '0;
            if (MEM_Busy && (act_state != ST_BAD)) begin
                wait_q <= wait_nxt;
                if (wait_nxt == WAIT_MAX) Timeout_Err <= 1'b1;
            end
            case (act_state)
                ST_RUN: begin
                    if (MEM_Busy) begin
                        ret_q   <= ST_RUN;
                        state_q <= ST_MEM_WAIT;
                    end else if (EX_BranchTaken) begin
                        if (Flush_Count != '1) Flush_Count <= Flush_Count + CNT_W'(1);
                        if (FLUSH_CYCLES > 1) begin
                            fcnt_q  <= FC_RELOAD;
                            state_q <= ST_FLUSH;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end else begin
                        if (load_use && (Stall_Count != '1)) Stall_Count <= Stall_Count + CNT_W'(1);
                        state_q <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (MEM_Busy) begin
                        ret_q   <= ST_FLUSH;
                        state_q <= ST_MEM_WAIT;
                    end else if (EX_BranchTaken) begin
                        if (Flush_Count != '1) Flush_Count <= Flush_Count + CNT_W'(1);
                        fcnt_q  <= FC_RELOAD;
                        state_q <= ST_FLUSH;
                    end else if ((fcnt_q == FC_W'(1)) || (fcnt_q == '0)) begin
                        state_q <= ST_RUN;
                    end else begin
                        fcnt_q  <= fcnt_q - FC_W'(1);
                        state_q <= ST_FLUSH;
                    end
                end
                ST_MEM_WAIT: state_q <= ST_MEM_WAIT;
                default:     state_q <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - vector table plus multi-cycle sequences for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] if_instr = '0;
    logic [31:0] ex_instr = '0;
    logic        mem_read = 1'b0;
    logic        br_taken = 1'b0;
    logic        mem_busy = 1'b0;

    logic        pcw_a, ifw_a, iff_a, ief_a, frz_a, err_a;
    logic [1:0]  st_a;
    logic [15:0] stall_a, flush_a;
    logic        pcw_b, ifw_b, iff_b, ief_b, frz_b, err_b;
    logic [1:0]  st_b;
    logic [1:0]  stall_b, flush_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl u_dut_a (
        .clk(clk), .reset(reset),
        .IF_ID_Instruction(if_instr), .ID_EX_Instruction(ex_instr),
        .ID_EX_MemRead(mem_read), .EX_BranchTaken(br_taken), .MEM_Busy(mem_busy),
        .PCWrite(pcw_a), .IF_ID_Write(ifw_a), .IF_ID_Flush(iff_a), .ID_EX_Flush(ief_a),
        .PipeFreeze(frz_a), .State(st_a), .Stall_Count(stall_a), .Flush_Count(flush_a),
        .Timeout_Err(err_a)
    );

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .TIMEOUT(4), .CNT_W(2)) u_dut_b (
        .clk(clk), .reset(reset),
        .IF_ID_Instruction(if_instr), .ID_EX_Instruction(ex_instr),
        .ID_EX_MemRead(mem_read), .EX_BranchTaken(br_taken), .MEM_Busy(mem_busy),
        .PCWrite(pcw_b), .IF_ID_Write(ifw_b), .IF_ID_Flush(iff_b), .ID_EX_Flush(ief_b),
        .PipeFreeze(frz_b), .State(st_b), .Stall_Count(stall_b), .Flush_Count(flush_b),
        .Timeout_Err(err_b)
    );

    // ctl bit order: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, PipeFreeze}
    typedef struct {
        logic [4:0] ctl;
        logic [1:0] st;
    } exp_t;

    typedef struct {
        logic [31:0] ifi;
        logic [31:0] exi;
        logic        mr;
        logic        br;
        logic        bz;
        logic [4:0]  ctl;
        logic [1:0]  st;
        logic [15:0] stall;
        logic [15:0] flush;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[16];

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] r1, input logic [4:0] r2);
        return {7'd0, r2, r1, 3'd0, rd, op};
    endfunction

    function automatic vec_t mkv(input logic [31:0] ifi, input logic [31:0] exi,
                                 input logic mr, input logic br, input logic bz,
                                 input logic [4:0] ctl, input logic [1:0] st,
                                 input logic [15:0] stall, input logic [15:0] flush);
        vec_t v;
        v.ifi = ifi; v.exi = exi; v.mr = mr; v.br = br; v.bz = bz;
        v.ctl = ctl; v.st = st; v.stall = stall; v.flush = flush;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Entered at posedge+1; drives, compares combinational outputs at negedge, returns at posedge+1.
    task automatic step(input logic [31:0] ifi, input logic [31:0] exi, input logic mr,
                        input logic br, input logic bz, input logic [4:0] ectl,
                        input logic [1:0] est, input bit use_b, input string nm);
        exp_t e;
        if_instr = ifi; ex_instr = exi; mem_read = mr; br_taken = br; mem_busy = bz;
        sb_q.push_back('{ctl: ectl, st: est});
        @(negedge clk);
        e = sb_q.pop_front();
        if (use_b) begin
            chk({nm, ".ctl"}, {27'd0, pcw_b, ifw_b, iff_b, ief_b, frz_b}, {27'd0, e.ctl});
            chk({nm, ".state"}, {30'd0, st_b}, {30'd0, e.st});
        end else begin
            chk({nm, ".ctl"}, {27'd0, pcw_a, ifw_a, iff_a, ief_a, frz_a}, {27'd0, e.ctl});
            chk({nm, ".state"}, {30'd0, st_a}, {30'd0, e.st});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b1;
        if_instr = '0; ex_instr = '0; mem_read = 1'b0; br_taken = 1'b0; mem_busy = 1'b0;
        #1;
        chk({nm, ".ctl_a"}, {27'd0, pcw_a, ifw_a, iff_a, ief_a, frz_a}, 32'b11000);
        chk({nm, ".cnt_a"}, {st_a, err_a, stall_a, flush_a}, 32'd0);
        chk({nm, ".ctl_b"}, {27'd0, pcw_b, ifw_b, iff_b, ief_b, frz_b}, 32'b11000);
        chk({nm, ".cnt_b"}, {27'd0, st_b, err_b, stall_b, flush_b}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] idle_if, idle_ex, lw5, lw0, add6, add_x0, lui5, sw5, addi5, beq5, jal5, auipc5, mv5;
        idle_if = mk(7'b0010011, 5'd1, 5'd0, 5'd0);
        idle_ex = mk(7'b0110011, 5'd0, 5'd0, 5'd0);
        lw5     = mk(7'b0000011, 5'd5, 5'd2, 5'd0);
        lw0     = mk(7'b0000011, 5'd0, 5'd2, 5'd0);
        mv5     = mk(7'b0110011, 5'd5, 5'd2, 5'd3);
        add6    = mk(7'b0110011, 5'd6, 5'd5, 5'd7);
        add_x0  = mk(7'b0110011, 5'd6, 5'd0, 5'd7);
        lui5    = mk(7'b0110111, 5'd5, 5'd5, 5'd5);
        sw5     = mk(7'b0100011, 5'd0, 5'd2, 5'd5);
        addi5   = mk(7'b0010011, 5'd1, 5'd1, 5'd5);
        beq5    = mk(7'b1100011, 5'd0, 5'd1, 5'd5);
        jal5    = mk(7'b1101111, 5'd1, 5'd5, 5'd5);
        auipc5  = mk(7'b0010111, 5'd1, 5'd5, 5'd5);

        tbl[0]  = mkv(idle_if, idle_ex, 0, 0, 0, 5'b11000, 2'b00, 0, 0);
        tbl[1]  = mkv(add6,    lw5,     1, 0, 0, 5'b00010, 2'b00, 1, 0);
        tbl[2]  = mkv(lui5,    lw5,     1, 0, 0, 5'b11000, 2'b00, 1, 0);
        tbl[3]  = mkv(sw5,     lw5,     1, 0, 0, 5'b00010, 2'b00, 2, 0);
        tbl[4]  = mkv(addi5,   lw5,     1, 0, 0, 5'b11000, 2'b00, 2, 0);
        tbl[5]  = mkv(add_x0,  lw0,     1, 0, 0, 5'b11000, 2'b00, 2, 0);
        tbl[6]  = mkv(add6,    mv5,     0, 0, 0, 5'b11000, 2'b00, 2, 0);
        tbl[7]  = mkv(beq5,    lw5,     1, 0, 0, 5'b00010, 2'b00, 3, 0);
        tbl[8]  = mkv(jal5,    lw5,     1, 0, 0, 5'b11000, 2'b00, 3, 0);
        tbl[9]  = mkv(idle_if, idle_ex, 0, 1, 0, 5'b11110, 2'b00, 3, 1);
        tbl[10] = mkv(add6,    lw5,     1, 1, 0, 5'b11110, 2'b00, 3, 2);
        tbl[11] = mkv(auipc5,  lw5,     1, 0, 0, 5'b11000, 2'b00, 3, 2);
        tbl[12] = mkv(idle_if, idle_ex, 0, 0, 1, 5'b00001, 2'b00, 3, 2);
        tbl[13] = mkv(add6,    lw5,     1, 1, 1, 5'b00001, 2'b10, 3, 2);
        tbl[14] = mkv(add6,    lw5,     1, 0, 0, 5'b00010, 2'b10, 4, 2);
        tbl[15] = mkv(idle_if, idle_ex, 0, 0, 0, 5'b11000, 2'b00, 4, 2);

        @(posedge clk);
        #1;
        do_reset("reset0");

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].ifi, tbl[i].exi, tbl[i].mr, tbl[i].br, tbl[i].bz,
                 tbl[i].ctl, tbl[i].st, 1'b0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.stall", i), {16'd0, stall_a}, {16'd0, tbl[i].stall});
            chk($sformatf("vec%0d.flush", i), {16'd0, flush_a}, {16'd0, tbl[i].flush});
        end

        do_reset("reset1");
        // three-cycle flush; load-use in FLUSH is ignored
        step(idle_if, idle_ex, 0, 1, 0, 5'b11110, 2'b00, 1'b1, "fl3.c0");
        step(add6,    lw5,     1, 0, 0, 5'b11100, 2'b01, 1'b1, "fl3.c1");
        step(idle_if, idle_ex, 0, 0, 0, 5'b11100, 2'b01, 1'b1, "fl3.c2");
        step(idle_if, idle_ex, 0, 0, 0, 5'b11000, 2'b00, 1'b1, "fl3.c3");
        chk("fl3.stall", {30'd0, stall_b}, 32'd0);
        chk("fl3.flush", {30'd0, flush_b}, 32'd1);
        step(add6, lw5, 1, 0, 0, 5'b00010, 2'b00, 1'b1, "lu_b");
        chk("lu_b.stall", {30'd0, stall_b}, 32'd1);

        // short wait from RUN, released before the timeout
        step(idle_if, idle_ex, 0, 0, 1, 5'b00001, 2'b00, 1'b1, "w3.c0");
        step(idle_if, idle_ex, 0, 0, 1, 5'b00001, 2'b10, 1'b1, "w3.c1");
        step(idle_if, idle_ex, 0, 0, 1, 5'b00001, 2'b10, 1'b1, "w3.c2");
        step(idle_if, idle_ex, 0, 0, 0, 5'b11000, 2'b10, 1'b1, "w3.rel");
        step(idle_if, idle_ex, 0, 0, 0, 5'b11000, 2'b00, 1'b1, "w3.after");
        chk("w3.err", {31'd0, err_b}, 32'd0);

        // branches in FLUSH reload the counter; Flush_Count saturates at 3
        step(idle_if, idle_ex, 0, 1, 0, 5'b11110, 2'b00, 1'b1, "rb.c0");
        step(idle_if, idle_ex, 0, 1, 0, 5'b11110, 2'b01, 1'b1, "rb.c1");
        step(idle_if, idle_ex, 0, 1, 0, 5'b11110, 2'b01, 1'b1, "rb.c2");
        chk("rb.flush_sat", {30'd0, flush_b}, 32'd3);
        // memory wait inside FLUSH with counter=2
        step(add6, lw5, 1, 0, 1, 5'b00001, 2'b01, 1'b1, "fw.c0");
        for (int i = 1; i < 4; i++)
            step(add6, lw5, 1, 1, 1, 5'b00001, 2'b10, 1'b1, $sformatf("fw.c%0d", i));
        step(idle_if, idle_ex, 0, 0, 0, 5'b11100, 2'b10, 1'b1, "fw.f1");
        step(idle_if, idle_ex, 0, 0, 0, 5'b11100, 2'b01, 1'b1, "fw.f2");
        step(idle_if, idle_ex, 0, 0, 0, 5'b11000, 2'b00, 1'b1, "fw.run");
        chk("fw.flush", {30'd0, flush_b}, 32'd3);
        chk("fw.stall", {30'd0, stall_b}, 32'd1);

        do_reset("reset2");
        // timeout after the 4th busy cycle, sticky after release
        for (int i = 0; i < 6; i++) begin
            step(idle_if, idle_ex, 0, 0, 1, 5'b00001, (i == 0) ? 2'b00 : 2'b10, 1'b1,
                 $sformatf("to.c%0d", i));
            chk($sformatf("to.err%0d", i), {31'd0, err_b}, (i >= 3) ? 32'd1 : 32'd0);
        end
        step(idle_if, idle_ex, 0, 0, 0, 5'b11000, 2'b10, 1'b1, "to.rel");
        chk("to.sticky", {31'd0, err_b}, 32'd1);
        step(idle_if, idle_ex, 0, 0, 1, 5'b00001, 2'b00, 1'b1, "mr.c0");
        step(idle_if, idle_ex, 0, 0, 1, 5'b00001, 2'b10, 1'b1, "mr.c1");

        // asynchronous reset mid-wait, away from the clock edge
        #2;
        reset = 1'b1;
        #1;
        chk("mr.ctl", {27'd0, pcw_b, ifw_b, iff_b, ief_b, frz_b}, 32'b11000);
        chk("mr.state", {30'd0, st_b}, 32'd0);
        chk("mr.err", {31'd0, err_b}, 32'd0);
        chk("mr.cnt", {28'd0, stall_b, flush_b}, 32'd0);
        @(posedge clk);
        #1;
        mem_busy = 1'b0;
        reset = 1'b0;
        step(idle_if, idle_ex, 0, 0, 0, 5'b11000, 2'b00, 1'b1, "mr.after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
